// File: rtl/alu_shift_seq.sv
// alu_shift_seq: multi-cycle shift unit that shifts one bit per clock.
// It supports LSL, LSR, ASR and ROR, and presents a tagged result
// {OPCODE, zero pad, data} together with a one-cycle done pulse.
// Optional feature macro: SHIFT_CARRY_EN adds the carry output, which holds
// the last bit shifted out.
module alu_shift_seq #(
    parameter int                WIDTH   = 6,
    parameter int                SHAMT_W = 3,
    parameter int                OP_W    = 2,
    parameter logic [OP_W-1:0]   OPCODE  = 2'b01,
    parameter int                PAD_W   = 4,
    parameter int                OUT_W   = OP_W + PAD_W + WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   x,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
`ifdef SHIFT_CARRY_EN
    output logic [OUT_W-1:0]   out,
    output logic               carry
`else
    output logic [OUT_W-1:0]   out
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] M_LSL = 2'b00;
    localparam logic [1:0] M_LSR = 2'b01;
    localparam logic [1:0] M_ASR = 2'b10;
    localparam logic [1:0] M_ROR = 2'b11;

    // The counter only ever holds an effective amount, which is at most WIDTH.
    localparam int CNT_W = $clog2(WIDTH + 1);
    // This width holds both a raw shamt value and the constant WIDTH.
    localparam int EW    = (SHAMT_W > CNT_W) ? SHAMT_W : CNT_W;
    localparam logic [EW-1:0]    WIDTH_E = EW'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] work_q,  work_d;
    logic [1:0]       mode_q,  mode_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [OUT_W-1:0] out_q,   out_d;

    logic [EW-1:0]    sh_ext;
    logic [CNT_W-1:0] eff_amt;
    logic [WIDTH-1:0] shifted;

    assign sh_ext = EW'(shamt);

    // Effective amount: ROR wraps modulo WIDTH; the other modes saturate at WIDTH.
    always_comb begin
        eff_amt = '0;
        if (mode == M_ROR) begin
            eff_amt = CNT_W'(sh_ext % WIDTH_E);
        end else if (sh_ext > WIDTH_E) begin
            eff_amt = CNT_W'(WIDTH_E);
        end else begin
            eff_amt = CNT_W'(sh_ext);
        end
    end

    // Single-bit step of the work register for the captured mode.
    always_comb begin
        shifted = work_q;
        case (mode_q)
            M_LSL:   shifted = {work_q[WIDTH-2:0], 1'b0};
            M_LSR:   shifted = {1'b0, work_q[WIDTH-1:1]};
            M_ASR:   shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shifted = {work_q[0], work_q[WIDTH-1:1]};
        endcase
    end

`ifdef SHIFT_CARRY_EN
    logic carry_q, carry_d;
    logic shift_carry;

    // Bit that falls off during a single step: the MSB for LSL, the LSB otherwise.
    always_comb begin
        shift_carry = (mode_q == M_LSL) ? work_q[WIDTH-1] : work_q[0];
    end

    // The carry is cleared on accept, tracks every step, and then holds.
    always_comb begin
        carry_d = carry_q;
        if (state_q == S_IDLE && start) begin
            carry_d = 1'b0;
        end else if (state_q == S_SHIFT) begin
            carry_d = shift_carry;
        end
    end

    // Carry register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry = carry_q;
`endif

    // Control FSM: the result is latched into out on the edge that enters DONE.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d = x;
                    mode_d = mode;
                    cnt_d  = eff_amt;
                    if (eff_amt == '0) begin
                        state_d = S_DONE;
                        out_d   = {OPCODE, {PAD_W{1'b0}}, x};
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                    out_d   = {OPCODE, {PAD_W{1'b0}}, shifted};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; an asserted reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            mode_q  <= M_LSL;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign out  = out_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// tb_alu_shift_seq: scoreboard bench for alu_shift_seq.
// The stimulus side pushes model results into a queue. A monitor pops an
// entry on every done pulse and checks data, carry, latency and busy length.
module tb_alu_shift_seq;
    localparam int W  = 6;
    localparam int SW = 3;
    localparam int OW = 2 + 4 + W;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode  = 2'b00;
    logic [W-1:0]  x     = '0;
    logic [SW-1:0] shamt = '0;
    logic          busy;
    logic          done;
    logic [OW-1:0] out;
`ifdef SHIFT_CARRY_EN
    logic          carry;
`endif

    always #5 clk = ~clk;

    alu_shift_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .x     (x),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
`ifdef SHIFT_CARRY_EN
        .out   (out),
        .carry (carry)
`else
        .out   (out)
`endif
    );

    typedef struct {
        logic [OW-1:0] out;
        logic          cy;
        int            eff;
        int            due;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic over the whole operand.
    function automatic exp_t model(input logic [1:0] m, input logic [W-1:0] xv,
                                   input logic [SW-1:0] sh);
        exp_t         e;
        int           n;
        int           sx;
        logic [2*W-1:0] dbl;
        logic [W-1:0] res;
        logic         cy;
        if (m == 2'b11) n = int'(sh) % W;
        else            n = (int'(sh) > W) ? W : int'(sh);
        cy  = 1'b0;
        res = xv;
        case (m)
            2'b00: begin
                res = (n >= W) ? '0 : W'(xv << n);
                if (n > 0) cy = xv[W-n];
            end
            2'b01: begin
                res = xv >> n;
                if (n > 0) cy = xv[n-1];
            end
            2'b10: begin
                sx  = xv[W-1] ? int'(xv) - (1 << W) : int'(xv);
                res = W'(sx >>> n);
                if (n > 0) cy = xv[n-1];
            end
            default: begin
                dbl = {xv, xv};
                res = W'(dbl >> n);
                if (n > 0) cy = xv[n-1];
            end
        endcase
        e.out = {2'b01, 4'b0000, res};
        e.cy  = cy;
        e.eff = n;
        e.due = 0;
        return e;
    endfunction

    // Issue one operation at the current negedge and stay until the unit is IDLE again.
    // Junk drives random start pulses and operands while busy; the unit must ignore them.
    task automatic issue(input logic [1:0] m, input logic [W-1:0] xv, input logic [SW-1:0] sh,
                         input int gap, input bit junk);
        exp_t e;
        e     = model(m, xv, sh);
        e.due = cyc + 1 + e.eff;
        q.push_back(e);
        start = 1'b1;
        mode  = m;
        x     = xv;
        shamt = sh;
        for (int i = 0; i <= e.eff; i++) begin
            @(negedge clk);
            if (junk) begin
                start = 1'($urandom);
                mode  = 2'($urandom);
                x     = W'($urandom);
                shamt = SW'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_out"},  64'(out),  64'd0);
`ifdef SHIFT_CARRY_EN
        check({tag, "_carry"}, 64'(carry), 64'd0);
`endif
    endtask

    // Monitor: checks each done pulse against the oldest outstanding expectation.
    initial begin
        int   busy_run;
        exp_t e;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (busy) busy_run++;
            else      busy_run = 0;
            if (done) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1, expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    check("out", 64'(out), 64'(e.out));
`ifdef SHIFT_CARRY_EN
                    check("carry", 64'(carry), 64'(e.cy));
`endif
                    check("latency", 64'(cyc), 64'(e.due));
                    check("busy_len", 64'(busy_run), 64'(e.eff + 1));
                    $display("txn: cycle %0d out=%b eff=%0d", cyc, out, e.eff);
                end
            end else if (q.size() > 0 && cyc > q[0].due) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missed_done: got no done, expected one by cycle %0d", q[0].due);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset");

        // Directed cases from the feature list.
        issue(2'b00, 6'b000111, 3'd2, 1, 1'b0);   // LSL by 2
        issue(2'b10, 6'b100100, 3'd7, 1, 1'b0);   // ASR saturating at WIDTH
        issue(2'b11, 6'b000011, 3'd7, 0, 1'b0);   // ROR 7 mod 6 = 1
        issue(2'b11, 6'b101010, 3'd0, 1, 1'b0);   // zero amount
        issue(2'b01, 6'b110000, 3'd4, 1, 1'b1);   // LSR with stray start pulses

        // Reset during SHIFT aborts the operation, and no done pulse may follow.
        start = 1'b1;
        mode  = 2'b01;
        x     = 6'b111111;
        shamt = 3'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(2'b00, 6'b000001, 3'd3, 1, 1'b0);

        // Back-to-back issue in the IDLE cycle right after DONE.
        issue(2'b00, 6'b000001, 3'd1, 0, 1'b0);
        issue(2'b00, 6'b000001, 3'd3, 1, 1'b0);

        // Randomized traffic.
        repeat (150) begin
            issue(2'($urandom), W'($urandom), SW'($urandom),
                  int'($urandom_range(2, 0)), 1'($urandom));
        end

        repeat (10) @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
